// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter in front of an 8N1 UART transmitter.
// Ports: iClk/iRst (async active-low), iValidN/iDataN/oReadyN per requester,
//        oTx serial line, oBusy frame active, oGntId owner of current/last frame.
module uart_tx_arbiter #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iValid0,
  input  logic       iValid1,
  input  logic [7:0] iData0,
  input  logic [7:0] iData1,
  output logic       oReady0,
  output logic       oReady1,
  output logic       oTx,
  output logic       oBusy,
  output logic       oGntId
);

  localparam int DIV = CLK_FREQ / BAUD_RATE;
  localparam logic [15:0] DIV_M1 = 16'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t      state, stateN;
  logic [15:0] cnt, cntN;
  logic [2:0]  idx, idxN;
  logic [7:0]  shReg, shRegN;
  logic        txQ, txN;
  logic        busyQ, busyN;
  logic        gntQ, gntN;
  // last granted requester; reset to 1 so requester 0 wins first contention
  logic        rrQ, rrN;

  logic        wrap;
  logic        anyReq;
  logic        pick;

  assign wrap   = (cnt == DIV_M1);
  // no accept while reset is held
  assign anyReq = iRst & (iValid0 | iValid1);
  assign pick   = (iValid0 & iValid1) ? ~rrQ : iValid1;

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shReg <= '0;
      txQ   <= 1'b1;
      busyQ <= 1'b0;
      gntQ  <= 1'b0;
      rrQ   <= 1'b1;
    end else begin
      state <= stateN;
      cnt   <= cntN;
      idx   <= idxN;
      shReg <= shRegN;
      txQ   <= txN;
      busyQ <= busyN;
      gntQ  <= gntN;
      rrQ   <= rrN;
    end
  end

  always_comb begin
    stateN  = state;
    cntN    = cnt;
    idxN    = idx;
    shRegN  = shReg;
    txN     = txQ;
    busyN   = busyQ;
    gntN    = gntQ;
    rrN     = rrQ;
    oReady0 = 1'b0;
    oReady1 = 1'b0;
    unique case (state)
      IDLE: begin
        txN   = 1'b1;
        busyN = 1'b0;
        if (anyReq) begin
          oReady0 = ~pick;
          oReady1 = pick;
          shRegN  = pick ? iData1 : iData0;
          gntN    = pick;
          rrN     = pick;
          cntN    = '0;
          idxN    = '0;
          stateN  = START;
          txN     = 1'b0;
          busyN   = 1'b1;
        end
      end
      START: begin
        if (wrap) begin
          cntN   = '0;
          idxN   = '0;
          stateN = DATA;
          txN    = shReg[0];
        end else begin
          cntN = cnt + 16'd1;
        end
      end
      DATA: begin
        if (wrap) begin
          cntN = '0;
          if (idx == 3'd7) begin
            stateN = STOP;
            txN    = 1'b1;
          end else begin
            // shift so the next bit always sits in shReg[0]
            idxN   = idx + 3'd1;
            shRegN = {1'b0, shReg[7:1]};
            txN    = shReg[1];
          end
        end else begin
          cntN = cnt + 16'd1;
        end
      end
      STOP: begin
        if (wrap) begin
          cntN   = '0;
          stateN = IDLE;
          txN    = 1'b1;
          busyN  = 1'b0;
        end else begin
          cntN = cnt + 16'd1;
        end
      end
      default: begin
        stateN = IDLE;
        txN    = 1'b1;
        busyN  = 1'b0;
      end
    endcase
  end

  assign oTx    = txQ;
  assign oBusy  = busyQ;
  assign oGntId = gntQ;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, serial bit rate in bit/s.
REQ-003 SHALL have port iClk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port iRst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports iValid0 / iValid1  input  1  requester 0/1 has a byte to send.
REQ-006 SHALL have ports iData0 / iData1  input  8  byte offered by requester 0/1.
REQ-007 SHALL have ports oReady0 / oReady1  output  1  one-cycle accept strobe to requester 0/1.
REQ-008 SHALL have port oTx  output  1  serial line, idle high.
REQ-009 SHALL have port oBusy  output  1  high while a frame is in progress.
REQ-010 SHALL have port oGntId  output  1  index of the requester owning the current or most recent frame.

Function
REQ-011 SHALL derive DIV = CLK_FREQ/BAUD_RATE (integer division); every bit period lasts exactly DIV cycles.
REQ-012 SHALL size the bit-period counter to hold DIV-1 for any DIV up to 65535.
REQ-013 SHALL implement states IDLE, START, DATA, STOP.
REQ-014 IDLE: oTx=1, oBusy=0; if any iValid is high, grant one requester, pulse its oReady for exactly that cycle, latch its iData, clear the bit-period counter and go to START next cycle.
REQ-015 Arbitration SHALL be round-robin: when both iValid are high, grant the requester not granted last; a single requester is granted immediately regardless of history.
REQ-016 Handshake: a transfer occurs only on a cycle where iValidN and oReadyN are both high; oReady0 and oReady1 SHALL never be high together.
REQ-017 oReady SHALL be asserted only in IDLE; iValid/iData changes outside IDLE SHALL have no effect on the frame in progress.
REQ-018 START: oTx=0 for DIV cycles, then DATA with bit index 0.
REQ-019 DATA: oTx drives latched bit[index], LSB first, each for DIV cycles; after index 7 completes go to STOP.
REQ-020 STOP: oTx=1 for DIV cycles, then IDLE; total frame length SHALL be 10*DIV cycles from the first START cycle.
REQ-021 oBusy SHALL be high in START, DATA and STOP, and low in IDLE.
REQ-022 Back-to-back: with a request pending at frame end, the next accept SHALL occur on the first IDLE cycle, giving exactly one idle-high cycle between the stop bit and the next start bit.
REQ-023 oTx, oBusy, oGntId SHALL be registered outputs (no combinational path from inputs to them).
REQ-024 The bit-period counter SHALL wrap to 0 on reaching DIV-1 and SHALL never exceed DIV-1.

Reset
REQ-025 While iRst=0: state=IDLE, oTx=1, oBusy=0, oReady0=oReady1=0, oGntId=0, counter=0, bit index=0, latched byte=0, round-robin pointer set so requester 0 wins the first contention.
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately (asynchronously) with oTx returning to 1; no partial frame resumes after release.
REQ-027 The first rising edge after iRst deasserts SHALL be able to perform an accept if iValid is high.

Verification (CLK_FREQ=50000000, BAUD_RATE=5000000, DIV=10)
REQ-028 Single send: iValid0=1, iData0=8'hA5 -> oReady0 one cycle; oTx=0 for 10 cycles, then bits 1,0,1,0,0,1,0,1 each 10 cycles, then 1 for 10 cycles; oBusy high 100 cycles; oGntId=0.
REQ-029 Contention: iValid0=iValid1=1 continuously, iData0=8'h11, iData1=8'h22 -> frames alternate 8'h11, 8'h22, 8'h11, with one idle cycle between frames; oGntId toggles 0,1,0.
REQ-030 Only requester 1: iValid1=1, iData1=8'h00 for two frames -> both granted to requester 1; oReady0 never high.
REQ-031 Data change mid-frame: accept 8'hFF, then drive iData0=8'h00 during DATA -> serialized bits all 1.
REQ-032 Reset at cycle 45 of a frame -> oTx=1, oBusy=0 immediately; after release with iValid0=1, iData0=8'h3C, a complete fresh 100-cycle frame is sent.
REQ-033 Default parameters: single send -> each bit lasts 5208 cycles.
